ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, RAM address width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request, requester 0 / requester 1.
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read; held stable while req high.
REQ-007 SHALL have ports a0/a1  input  ADDR_WIDTH  address; held stable while req high.
REQ-008 SHALL have ports x0/x1  input  DATA_WIDTH  write data; held stable while req high.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports y0/y1  output  DATA_WIDTH  read data, valid during ackN of a read.
REQ-011 SHALL have ports ram_a / ram_x  output  ADDR_WIDTH / DATA_WIDTH  RAM address and write data.
REQ-012 SHALL have ports ram_we, ram_re0, ram_re1  output  1  RAM write enable; read enables for RAM read ports 0 and 1.
REQ-013 SHALL have port ram_y  input  DATA_WIDTH  RAM read data bus.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCESS, WAIT, DONE.
REQ-016 IDLE: sample req0/req1; if any high, latch granted id, we, a, x; go to ACCESS; otherwise stay.
REQ-017 ACCESS: drive ram_a/ram_x from latched values; on write, ram_we=1 for exactly this cycle, then go to DONE; on read, ram_reN=1 (N = granted id), then go to WAIT.
REQ-018 WAIT (reads only): hold ram_a and ram_reN=1; capture ram_y into yN at end of cycle; go to DONE.
REQ-019 DONE: ackN=1 for exactly this cycle; go to IDLE unconditionally.
REQ-020 Latency, req sampled in IDLE at cycle 0: write ack in cycle 2; read ack with data in cycle 3.
REQ-021 req is ignored outside IDLE; req still high in the IDLE cycle after ack SHALL start a new transaction.
REQ-022 Only one of ram_we, ram_re0, ram_re1 SHALL be high in any cycle; all low in IDLE and DONE.
REQ-023 yN SHALL hold its last read value until the next read by requester N; writes leave y0/y1 unchanged.
REQ-024 Both requests high in IDLE: arbitration per REQ-029/REQ-030; the loser stays pending and is granted in the next IDLE cycle.
REQ-025 ram_a/ram_x SHALL hold their last latched values in IDLE and DONE.

Reset
REQ-026 rst high at a clock edge SHALL force state IDLE, ack0=ack1=0, y0=y1=0, latched a/x = 0, and round-robin pointer = last-granted 1.
REQ-027 ram_we, ram_re0, ram_re1 SHALL be gated low combinationally while rst is high, so a reset in ACCESS or WAIT aborts the access without a RAM write.
REQ-028 An access aborted by reset SHALL NOT produce an ack; requesters re-request after reset.

Configuration
REQ-029 With RAM_ARB_RR_EN defined: round robin; on simultaneous requests, grant the requester not granted last; the pointer updates on every grant.
REQ-030 Without RAM_ARB_RR_EN: fixed priority; requester 0 always wins simultaneous requests; no pointer register.

Verification
REQ-031 rst, then req0 write a0=16'h0010, x0=8'hA5 -> ram_we high in cycle 1 only, ram_a=16'h0010, ram_x=8'hA5; ack0 in cycle 2.
REQ-032 Preload m[16'h0020]=8'h3C; req1 read a1=16'h0020 -> ram_re1 high in cycles 1-2; ack1 in cycle 3 with y1=8'h3C; ram_re0 and ram_we stay low.
REQ-033 Both req0 and req1 held high for 4 transactions -> with RAM_ARB_RR_EN, grants 0,1,0,1; without it, all grants go to 0 and req1 waits.
REQ-034 Read in progress; rst high in WAIT cycle -> ram_re1 low that cycle, no ack1, busy=0 next cycle, y1=0.
REQ-035 Write in progress; rst high in ACCESS cycle -> ram_we low; target address keeps its old value on readback.
REQ-036 req0 held high through ack0 -> ack0 cycle ignored as a request; next IDLE cycle starts a new transaction; ack pulses never exceed 1 cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-requester arbiter in front of a single-port-write /
//            dual-read-enable RAM. Each transaction is sampled in IDLE, then
//            executed as ACCESS (+ WAIT for reads) and completed with a
//            one-cycle ack in DONE.
//            Write latency: ack two cycles after the request is sampled.
//            Read latency : ack three cycles after, with data on yN.
// Config   : define RAM_ARB_RR_EN for round-robin arbitration on
//            simultaneous requests; otherwise requester 0 has fixed priority.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            req0/req1             - access requests
//            we0/we1, a0/a1, x0/x1 - write flag, address, write data
//            ack0/ack1             - one-cycle completion pulses
//            y0/y1                 - last read data per requester
//            ram_a, ram_x          - RAM address / write data
//            ram_we                - RAM write enable
//            ram_re0, ram_re1      - RAM read enables (read ports 0 / 1)
//            ram_y                 - RAM read data
//            busy                  - high whenever not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] a0,
  input  logic [ADDR_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] x1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] y0,
  output logic [DATA_WIDTH-1:0] y1,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_x,
  output logic                  ram_we,
  output logic                  ram_re0,
  output logic                  ram_re1,
  input  logic [DATA_WIDTH-1:0] ram_y,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;

  // Latched transaction
  logic                  r_id;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_y0;
  logic [DATA_WIDTH-1:0] r_y1;

  logic                  w_grant_valid;
  logic                  w_grant_id;
  logic                  w_take;

  assign w_grant_valid = req0 | req1;
  assign w_take        = (r_state == S_IDLE) && w_grant_valid;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef RAM_ARB_RR_EN
  // Last-granted requester; resets to 1 so requester 0 wins the first tie.
  logic r_last;

  always_comb begin
    w_grant_id = 1'b0;
    if (req0 && req1) begin
      w_grant_id = ~r_last;
    end else if (req1) begin
      w_grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_grant_id;
    end
  end
`else
  // Requester 1 only wins when requester 0 is not asking.
  assign w_grant_id = ~req0 & req1;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Writes complete in one RAM cycle; reads need a data cycle.
        w_next_state = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    ram_we  = 1'b0;
    ram_re0 = 1'b0;
    ram_re1 = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    busy    = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_ACCESS: begin
        ram_we  = r_we;
        ram_re0 = ~r_we & ~r_id;
        ram_re1 = ~r_we &  r_id;
      end
      S_WAIT: begin
        ram_re0 = ~r_id;
        ram_re1 =  r_id;
      end
      S_DONE: begin
        ack0 = ~r_id;
        ack1 =  r_id;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
    // Reset aborts any access in flight without touching the RAM.
    if (rst) begin
      ram_we  = 1'b0;
      ram_re0 = 1'b0;
      ram_re1 = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: request latch and read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id <= 1'b0;
      r_we <= 1'b0;
      r_a  <= '0;
      r_x  <= '0;
      r_y0 <= '0;
      r_y1 <= '0;
    end else begin
      if (w_take) begin
        r_id <= w_grant_id;
        r_we <= w_grant_id ? we1 : we0;
        r_a  <= w_grant_id ? a1  : a0;
        r_x  <= w_grant_id ? x1  : x0;
      end
      // RAM data is valid during WAIT; capture it so it is on yN at ack.
      if (r_state == S_WAIT) begin
        if (r_id) begin
          r_y1 <= ram_y;
        end else begin
          r_y0 <= ram_y;
        end
      end
    end
  end

  assign ram_a = r_a;
  assign ram_x = r_x;
  assign y0    = r_y0;
  assign y1    = r_y1;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter: directed transaction table,
//            reset/abort and arbitration sequences, and a randomized run
//            compared against a transaction-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 16;
`ifdef RAM_ARB_RR_EN
  localparam int WAIT_BOUND = 12;
`else
  localparam int WAIT_BOUND = 500;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] x0 = '0, x1 = '0;
  logic          ack0, ack1, ram_we, ram_re0, ram_re1, busy;
  logic [DW-1:0] y0, y1, ram_x, ram_y;
  logic [AW-1:0] ram_a;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .x0(x0), .x1(x1),
    .ack0(ack0), .ack1(ack1), .y0(y0), .y1(y1),
    .ram_a(ram_a), .ram_x(ram_x),
    .ram_we(ram_we), .ram_re0(ram_re0), .ram_re1(ram_re1),
    .ram_y(ram_y), .busy(busy)
  );

  // Synchronous RAM with a registered read and a bench preload port.
  logic [DW-1:0] mem [0:65535];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (ram_we) mem[ram_a] <= ram_x;
    if (ram_re0 || ram_re1) ram_y <= mem[ram_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  // Issue one transaction from IDLE and check strobes, latency and y values.
  task automatic run_txn(input logic id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] x, input int exp_lat,
                         input logic [DW-1:0] ey0, input logic [DW-1:0] ey1);
    int lat;
    lat = 0;
    if (id) begin req1 = 1'b1; we1 = we; a1 = a; x1 = x; end
    else    begin req0 = 1'b1; we0 = we; a0 = a; x0 = x; end
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      tick;
      if (c == 1) begin
        req0 = 1'b0; req1 = 1'b0;
        chk("acc_we",  32'(ram_we),  32'(we));
        chk("acc_re0", 32'(ram_re0), 32'(!we && !id));
        chk("acc_re1", 32'(ram_re1), 32'(!we && id));
        chk("acc_a",   32'(ram_a),   32'(a));
        if (we) chk("acc_x", 32'(ram_x), 32'(x));
      end
      if (c == 2 && !we) begin
        chk("wait_re",   32'(id ? ram_re1 : ram_re0), 32'd1);
        chk("wait_othr", 32'(ram_we | (id ? ram_re0 : ram_re1)), 32'd0);
      end
      chk("other_ack", 32'(id ? ack0 : ack1), 32'd0);
      if (id ? ack1 : ack0) lat = c;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("y0", 32'(y0), 32'(ey0));
    chk("y1", 32'(y1), 32'(ey1));
    tick;
    chk("idle_busy",    32'(busy), 32'd0);
    chk("idle_strobes", 32'({ram_we, ram_re0, ram_re1}), 32'd0);
    chk("hold_a",       32'(ram_a), 32'(a));
  endtask

  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] x;
    int            lat;
    logic [DW-1:0] ey0;
    logic [DW-1:0] ey1;
  } vec_t;

  vec_t vecs [8];

  // Randomized-phase model state
  logic [DW-1:0] ref_mem [16];
  logic [1:0]    pend, pwe, prev_ack, ack_v;
  logic [3:0]    pa [2];
  logic [DW-1:0] px [2];
  logic [DW-1:0] ey [2];
  int            pw [2];
  int            ng;
  int            exp_g;

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    tick; tick;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_y0",   32'(y0),   32'd0);
    chk("rst_y1",   32'(y1),   32'd0);
    chk("rst_ram_a", 32'(ram_a), 32'd0);
    chk("rst_ram_x", 32'(ram_x), 32'd0);
    chk("rst_strobes", 32'({ram_we, ram_re0, ram_re1}), 32'd0);
    rst = 1'b0;
    preload(16'h0020, 8'h3C);
    preload(16'h0030, 8'h11);

    // ---------------- directed transaction table ----------------
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 8'hA5, 2, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 16'h0020, 8'h00, 3, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 16'h0010, 8'h00, 3, 8'hA5, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 16'h0010, 8'h5A, 2, 8'hA5, 8'h3C};
    vecs[4] = '{1'b0, 1'b0, 16'h0010, 8'h00, 3, 8'h5A, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 8'h00, 3, 8'h5A, 8'h5A};
    vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 8'h81, 2, 8'h5A, 8'h5A};
    vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 3, 8'h81, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].id, vecs[i].we, vecs[i].a, vecs[i].x,
              vecs[i].lat, vecs[i].ey0, vecs[i].ey1);
    end

    // ---------------- reset during a read's WAIT cycle ----------------
    req1 = 1'b1; we1 = 1'b0; a1 = 16'h0020;
    tick;
    req1 = 1'b0;
    chk("abort_rd_access", 32'(ram_re1), 32'd1);
    tick;
    chk("abort_rd_wait", 32'(ram_re1), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rd_gate", 32'(ram_re1), 32'd0);
    tick;
    rst = 1'b0;
    chk("abort_rd_ack",  32'(ack1), 32'd0);
    chk("abort_rd_busy", 32'(busy), 32'd0);
    chk("abort_rd_y1",   32'(y1),   32'd0);
    tick;
    chk("abort_rd_late_ack", 32'({ack0, ack1}), 32'd0);

    // ---------------- reset during a write's ACCESS cycle ----------------
    req0 = 1'b1; we0 = 1'b1; a0 = 16'h0030; x0 = 8'hEE;
    tick;
    req0 = 1'b0;
    chk("abort_wr_access", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_wr_gate", 32'(ram_we), 32'd0);
    tick;
    rst = 1'b0;
    chk("abort_wr_ack",  32'(ack0), 32'd0);
    chk("abort_wr_busy", 32'(busy), 32'd0);
    run_txn(1'b0, 1'b0, 16'h0030, 8'h00, 3, 8'h11, 8'h00);

    // ---------------- request held high through ack ----------------
    req0 = 1'b1; we0 = 1'b1; a0 = 16'h0050; x0 = 8'h77;
    for (int c = 1; c <= 5; c++) begin
      tick;
      chk("held_ack0", 32'(ack0), 32'(c == 2 || c == 5));
      chk("held_ack1", 32'(ack1), 32'd0);
      if (c == 3) chk("held_idle_busy", 32'(busy), 32'd0);
    end
    req0 = 1'b0;
    tick;
    chk("held_end_busy", 32'(busy), 32'd0);
    tick;
    chk("held_no_extra", 32'(busy), 32'd0);

    // ---------------- simultaneous requests ----------------
    do_reset;
    req0 = 1'b1; we0 = 1'b1; a0 = 16'h0040; x0 = 8'h01;
    req1 = 1'b1; we1 = 1'b1; a1 = 16'h0041; x1 = 8'h02;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick;
      if (ack0 || ack1) begin
`ifdef RAM_ARB_RR_EN
        exp_g = ng % 2;
`else
        exp_g = 0;
`endif
        chk("grant_excl",  32'(ack0 & ack1), 32'd0);
        chk("grant_order", 32'(ack1), 32'(exp_g));
        ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    chk("grant_count", 32'(ng), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    tick; tick;

    // ---------------- randomized run against memory model ----------------
    do_reset;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      preload(AW'(i), ref_mem[i]);
    end
    pend = '0; pwe = '0; prev_ack = '0;
    for (int n = 0; n < 2; n++) begin
      pa[n] = '0; px[n] = '0; ey[n] = '0; pw[n] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick;
      ack_v = {ack1, ack0};
      chk("rand_onehot", 32'($countones({ram_we, ram_re0, ram_re1}) <= 1), 32'd1);
      chk("rand_ack_excl", 32'(ack0 & ack1), 32'd0);
      for (int n = 0; n < 2; n++) begin
        if (ack_v[n]) begin
          chk("rand_ack_pending", 32'(pend[n]), 32'd1);
          chk("rand_ack_width", 32'(prev_ack[n]), 32'd0);
          if (pend[n]) begin
            if (pwe[n]) ref_mem[pa[n]] = px[n];
            else        ey[n] = ref_mem[pa[n]];
            pend[n] = 1'b0;
          end
        end
      end
      chk("rand_y0", 32'(y0), 32'(ey[0]));
      chk("rand_y1", 32'(y1), 32'(ey[1]));
      prev_ack = ack_v;
      for (int n = 0; n < 2; n++) begin
        if (pend[n]) begin
          pw[n]++;
          if (pw[n] > WAIT_BOUND) begin
            chk("rand_timeout", 32'(pw[n]), 32'(WAIT_BOUND));
            pend[n] = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          pend[n] = 1'b1;
          pwe[n]  = 1'($urandom_range(1));
          pa[n]   = 4'($urandom_range(15));
          px[n]   = 8'($urandom);
          pw[n]   = 0;
        end
      end
      req0 = pend[0]; we0 = pwe[0]; a0 = {12'h000, pa[0]}; x0 = px[0];
      req1 = pend[1]; we1 = pwe[1]; a1 = {12'h000, pa[1]}; x1 = px[1];
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
